// File: rtl/limits_buffer_pkg.sv
// Shared types and field layout for the limit-pair buffer.
package limits_buffer_pkg;

    localparam int unsigned LIM_W  = 16;
    localparam int unsigned PAIR_W = 32;
    localparam int unsigned MAX_HI = 31;
    localparam int unsigned MAX_LO = 16;
    localparam int unsigned MIN_HI = 15;
    localparam int unsigned MIN_LO = 0;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_REPLAY  = 2'd2,
        ST_DONE    = 2'd3
    } LIMBUFF_STATE_T;

    // A pair is inconsistent when its signed min exceeds its signed max.
    function automatic logic pair_invalid(input logic [PAIR_W-1:0] pair);
        logic signed [LIM_W-1:0] max_v;
        logic signed [LIM_W-1:0] min_v;
        max_v = pair[MAX_HI:MAX_LO];
        min_v = pair[MIN_HI:MIN_LO];
        return min_v > max_v;
    endfunction

endpackage

// File: rtl/limits_buffer_ram.sv
// Simple dual-port DEPTH x PAIR_W storage, one-cycle registered read.
module limits_buffer_ram
    import limits_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [PAIR_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [PAIR_W-1:0] rd_data_o
);

    logic [PAIR_W-1:0] mem_q [DEPTH];
    logic [PAIR_W-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register carries an async clear so data reads zero during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/limits_buffer_ctrl.sv
// Loads limit pairs once, then replays them in order for each FIR iteration.
module limits_buffer_ctrl
    import limits_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PAIR_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              iter_new_signal,
    input  logic              iter_clear,
    output logic [PAIR_W-1:0] limbuff_data,
    output logic              limbuff_valid,
    input  logic              limbuff_ready,
    output logic [AW:0]       fill_level,
    output logic              invalid_pair,
    output logic              overflow_err
);

    LIMBUFF_STATE_T state_q, state_d;
    logic [AW:0]    fill_q, fill_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           valid_q, valid_d;
    logic           prime_q, prime_d;
    logic           in_ready_q, in_ready_d;
    logic           invalid_q, invalid_d;
    logic           ovf_q, ovf_d;
    logic           wr_en_c, hs_c, last_c, full_c;
    logic [AW-1:0]  rd_addr_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            fill_q     <= '0;
            rd_ptr_q   <= '0;
            valid_q    <= 1'b0;
            prime_q    <= 1'b0;
            in_ready_q <= 1'b0;
            invalid_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            rd_ptr_q   <= rd_ptr_d;
            valid_q    <= valid_d;
            prime_q    <= prime_d;
            in_ready_q <= in_ready_d;
            invalid_q  <= invalid_d;
            ovf_q      <= ovf_d;
        end
    end

    // prime_q marks the refill cycle while the RAM fetches entry 0.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        rd_ptr_d  = rd_ptr_q;
        valid_d   = valid_q;
        prime_d   = 1'b0;
        invalid_d = invalid_q;
        ovf_d     = ovf_q;

        full_c  = (fill_q == (AW+1)'(DEPTH));
        wr_en_c = in_valid && in_ready_q && !iter_clear;
        hs_c    = valid_q && limbuff_ready;
        last_c  = (((AW+1)'(rd_ptr_q) + (AW+1)'(1)) == fill_q);

        if (wr_en_c) begin
            fill_d = fill_q + (AW+1)'(1);
            if (pair_invalid(in_data)) begin
                invalid_d = 1'b1;
            end
        end
        if (!iter_clear && in_valid && (state_q == ST_LOADING) && full_c) begin
            ovf_d = 1'b1;
        end

        if (iter_clear) begin
            state_d   = ST_EMPTY;
            fill_d    = '0;
            rd_ptr_d  = '0;
            valid_d   = 1'b0;
            invalid_d = 1'b0;
            ovf_d     = 1'b0;
        end else if (iter_new_signal && (state_q != ST_EMPTY)) begin
            state_d  = ST_REPLAY;
            rd_ptr_d = '0;
            valid_d  = 1'b0;
            prime_d  = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (wr_en_c) begin
                        state_d = ST_LOADING;
                    end
                end
                ST_REPLAY: begin
                    if (prime_q) begin
                        valid_d = 1'b1;
                    end else if (hs_c) begin
                        if (last_c) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        in_ready_d = ((state_d == ST_EMPTY) || (state_d == ST_LOADING)) &&
                     (fill_d != (AW+1)'(DEPTH));
        // Lookahead: present the next pointer so the RAM output never bubbles.
        rd_addr_c = rd_ptr_d;
    end

    limits_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (fill_q[AW-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (limbuff_data)
    );

    assign in_ready      = in_ready_q;
    assign limbuff_valid = valid_q;
    assign fill_level    = fill_q;
    assign invalid_pair  = invalid_q;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_limits_buffer_ctrl.sv
// Directed scoreboard bench for limits_buffer_ctrl.
module tb_limits_buffer_ctrl;

    localparam int unsigned TB_DEPTH = 16;
    localparam int unsigned TB_AW    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic              iter_new_signal;
    logic              iter_clear;
    logic [31:0]       limbuff_data;
    logic              limbuff_valid;
    logic              limbuff_ready;
    logic [TB_AW:0]    fill_level;
    logic              invalid_pair;
    logic              overflow_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl[$];
    logic [31:0] exp_q[$];

    limits_buffer_ctrl #(.DEPTH(TB_DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .iter_new_signal (iter_new_signal),
        .iter_clear      (iter_clear),
        .limbuff_data    (limbuff_data),
        .limbuff_valid   (limbuff_valid),
        .limbuff_ready   (limbuff_ready),
        .fill_level      (fill_level),
        .invalid_pair    (invalid_pair),
        .overflow_err    (overflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mkp(input int mx, input int mn);
        return {16'(mx), 16'(mn)};
    endfunction

    task automatic wr(input logic [31:0] p);
        in_valid = 1'b1;
        in_data  = p;
        mdl.push_back(p);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        iter_clear = 1'b1;
        tick();
        iter_clear = 1'b0;
        mdl.delete();
    endtask

    // Pulse iter_new_signal, expect refill cycle then valid.
    task automatic start_replay();
        exp_q.delete();
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        limbuff_ready   = 1'b0;
        iter_new_signal = 1'b1;
        tick();
        iter_new_signal = 1'b0;
        chk("refill_valid_low", 32'(limbuff_valid), 32'd0);
        tick();
        chk("latency_valid_high", 32'(limbuff_valid), 32'd1);
    endtask

    task automatic consume(input int n, input bit toggle);
        int got;
        int cyc;
        logic [31:0] e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 4 * n + 20) begin
            if (toggle) limbuff_ready = ((cyc % 2) == 0);
            else        limbuff_ready = 1'b1;
            if (limbuff_valid) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
                chk("replay_data", limbuff_data, e);
                if (limbuff_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got++;
                end
            end
            tick();
            cyc++;
        end
        limbuff_ready = 1'b0;
        chk("replay_count", 32'(got), 32'(n));
    endtask

    initial begin
        reset = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        iter_new_signal = 1'b0;
        iter_clear = 1'b0;
        limbuff_ready = 1'b0;

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(limbuff_valid), 32'd0);
        chk("rst_data", limbuff_data, 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_flags", {30'd0, invalid_pair, overflow_err}, 32'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Basic load and full-rate replay.
        wr(mkp(100, -100));
        wr(mkp(50, -50));
        wr(mkp(10, -10));
        wr(mkp(0, 0));
        chk("fill_after_load", 32'(fill_level), 32'd4);
        chk("no_invalid", 32'(invalid_pair), 32'd0);
        start_replay();
        consume(4, 1'b0);
        chk("done_valid_low", 32'(limbuff_valid), 32'd0);
        chk("done_in_ready_low", 32'(in_ready), 32'd0);

        // Replay from DONE with back-pressure.
        start_replay();
        consume(4, 1'b1);
        chk("done2_valid_low", 32'(limbuff_valid), 32'd0);

        // Restart in the middle of a replay.
        start_replay();
        consume(2, 1'b0);
        start_replay();
        consume(4, 1'b0);
        chk("restart_done_valid", 32'(limbuff_valid), 32'd0);

        // Inverted pair is flagged but stored unchanged.
        do_clear();
        chk("clear_fill", 32'(fill_level), 32'd0);
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        wr(mkp(-5, 5));
        chk("invalid_set", 32'(invalid_pair), 32'd1);
        start_replay();
        consume(1, 1'b0);
        chk("inv_done_valid", 32'(limbuff_valid), 32'd0);
        do_clear();
        chk("invalid_cleared", 32'(invalid_pair), 32'd0);
        chk("inv_clear_fill", 32'(fill_level), 32'd0);
        chk("inv_clear_ready", 32'(in_ready), 32'd1);

        // Clear wins over new-iteration; EMPTY ignores new-iteration.
        wr(mkp(7, 1));
        wr(mkp(8, 2));
        start_replay();
        iter_clear = 1'b1;
        iter_new_signal = 1'b1;
        tick();
        iter_clear = 1'b0;
        iter_new_signal = 1'b0;
        mdl.delete();
        chk("clr_new_valid", 32'(limbuff_valid), 32'd0);
        chk("clr_new_fill", 32'(fill_level), 32'd0);
        iter_new_signal = 1'b1;
        tick();
        iter_new_signal = 1'b0;
        chk("empty_ignore_new_a", 32'(limbuff_valid), 32'd0);
        tick();
        chk("empty_ignore_new_b", 32'(limbuff_valid), 32'd0);
        chk("empty_in_ready", 32'(in_ready), 32'd1);

        // Write colliding with new-iteration is stored first.
        wr(mkp(300, 200));
        wr(mkp(-1, -2));
        in_valid = 1'b1;
        in_data = mkp(42, -42);
        mdl.push_back(in_data);
        exp_q.delete();
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        iter_new_signal = 1'b1;
        tick();
        in_valid = 1'b0;
        iter_new_signal = 1'b0;
        chk("collide_refill", 32'(limbuff_valid), 32'd0);
        tick();
        chk("collide_valid", 32'(limbuff_valid), 32'd1);
        chk("collide_fill", 32'(fill_level), 32'd3);
        consume(3, 1'b0);

        // Fill to DEPTH, then overflow attempt.
        do_clear();
        for (int i = 0; i < int'(TB_DEPTH); i++) wr($urandom());
        chk("full_fill", 32'(fill_level), 32'(TB_DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_fill", 32'(fill_level), 32'(TB_DEPTH));
        start_replay();
        consume(int'(TB_DEPTH), 1'b0);
        chk("full_done_valid", 32'(limbuff_valid), 32'd0);
        do_clear();
        chk("ovf_cleared", 32'(overflow_err), 32'd0);

        // Async reset mid-replay.
        wr(mkp(100, -100));
        wr(mkp(50, -50));
        wr(mkp(10, -10));
        wr(mkp(0, 0));
        start_replay();
        consume(2, 1'b0);
        chk("entry2_on_bus", limbuff_data, mdl[2]);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(limbuff_valid), 32'd0);
        chk("async_rst_data", limbuff_data, 32'd0);
        chk("async_rst_fill", 32'(fill_level), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("rerelease_in_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/limits_buffer_ctrl.md
LIMITS_BUFFER_CTRL -- requirements
Module: limits_buffer_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, number of limit-pair entries; power of two, at least 2.
REQ-002 Parameter AW, default $clog2(DEPTH), entry address width.
REQ-003 clock  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  32  limit pair; [31:16] signed max, [15:0] signed min.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_ready  out  1  block accepts in_data.
REQ-008 iter_new_signal  in  1  one-cycle pulse; start replay from entry 0.
REQ-009 iter_clear  in  1  one-cycle pulse; discard all stored entries.
REQ-010 limbuff_data  out  32  current limit pair, same field layout as in_data.
REQ-011 limbuff_valid  out  1  limbuff_data valid.
REQ-012 limbuff_ready  in  1  consumer took the current pair (one FIR sample processed).
REQ-013 fill_level  out  AW+1  number of stored entries, 0..DEPTH.
REQ-014 invalid_pair  out  1  sticky; some accepted pair had min > max.
REQ-015 overflow_err  out  1  sticky; in_valid was high while full in LOADING.

Function
REQ-016 The block shall have four states: EMPTY, LOADING, REPLAY, DONE.
REQ-017 Input handshake: in_ready = (EMPTY or LOADING) and fill_level < DEPTH; write on in_valid & in_ready at address fill_level, then fill_level +1.
REQ-018 EMPTY -> LOADING on the first accepted write.
REQ-019 LOADING -> REPLAY on iter_new_signal; the read pointer loads 0.
REQ-020 iter_new_signal in EMPTY shall be ignored; state stays EMPTY and limbuff_valid stays 0.
REQ-021 REPLAY: limbuff_valid shall be 1 and limbuff_data = entry[rd_ptr]; on limbuff_valid & limbuff_ready, rd_ptr +1.
REQ-022 Throughput: one pair per cycle; after a handshake at cycle N, entry rd_ptr+1 shall be on limbuff_data at cycle N+1 with no bubble.
REQ-023 Latency: first pair shall be valid exactly 2 cycles after the iter_new_signal cycle.
REQ-024 REPLAY -> DONE on handshake of entry fill_level-1; limbuff_valid = 0 in DONE; rd_ptr shall not wrap.
REQ-025 DONE -> REPLAY on iter_new_signal; rd_ptr reloads 0, same 2-cycle latency.
REQ-026 iter_new_signal during REPLAY shall restart the replay at entry 0; limbuff_valid drops for the 2-cycle refill.
REQ-027 iter_clear from any state -> EMPTY; fill_level, rd_ptr, invalid_pair and overflow_err shall clear next cycle; memory contents are not cleared.
REQ-028 Priority on the same cycle: iter_clear > iter_new_signal > in_valid write; a write colliding with iter_new_signal in LOADING shall be stored before replay starts.
REQ-029 in_valid while fill_level == DEPTH in LOADING shall set overflow_err; no data is written.
REQ-030 Accepted pair with signed min > signed max shall set invalid_pair; the pair is still stored unchanged.
REQ-031 limbuff_data shall be registered; no combinational path from limbuff_ready or in_valid to any output.

Reset
REQ-032 On reset low: state = EMPTY, fill_level = 0, rd_ptr = 0, limbuff_valid = 0, limbuff_data = 0, in_ready = 0 while asserted, invalid_pair = 0, overflow_err = 0.
REQ-033 After reset deasserts, in_ready shall rise on the first clock edge.
REQ-034 Reset mid-replay shall drop limbuff_valid immediately, asynchronously.

Structure
REQ-035 Package limits_buffer_pkg shall hold the state enum LIMBUFF_STATE_T, LIM_W = 16, PAIR_W = 32, and the field-slice constants MAX_HI/MAX_LO/MIN_HI/MIN_LO.
REQ-036 Storage shall be the sub-module limits_buffer_ram: simple dual-port, DEPTH x 32, synchronous read, one cycle of read latency, inferable as M10K.
REQ-037 Read-address lookahead (rd_ptr+1 on handshake) shall be generated in limits_buffer_ctrl.

Verification
REQ-038 Load 4 pairs {100,-100},{50,-50},{10,-10},{0,0}, pulse iter_new_signal, hold limbuff_ready=1 -> limbuff_valid at +2 cycles, 4 consecutive valid cycles in order, then DONE with valid=0.
REQ-039 Same load, toggle limbuff_ready 1,0,1,0 -> each pair held stable while ready=0, no skipped or repeated entry.
REQ-040 Write DEPTH pairs, then one more with in_valid=1 -> in_ready=0, overflow_err=1, fill_level=DEPTH.
REQ-041 Write pair {max=-5,min=5} -> invalid_pair=1 and pair replayed unchanged; iter_clear -> invalid_pair=0, fill_level=0, state EMPTY.
REQ-042 Pulse iter_clear and iter_new_signal on the same cycle during REPLAY -> EMPTY, limbuff_valid=0; a second iter_new_signal is ignored.
REQ-043 Assert reset while entry 2 of 4 is on limbuff_data -> limbuff_valid=0 before the next edge; all outputs at reset values.
